vga_screen_sequencer: RTL and testbench

//  Screen-level controller between vga_controller and the per-screen pixel generators (title/play/win/lose).

---
 rtl/vga_screen_if.sv | 34 +++
 rtl/vga_screen_sequencer.sv | 164 ++++++++++++++++
 tb/tb_vga_screen_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_screen_if.sv
// Bundle between the VGA timing generator, the per-screen pixel generators, game logic and the screen sequencer.
interface vga_screen_if;
  logic        valid;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        hsync_in;
  logic        vsync_in;
  logic        start_btn;
  logic        win_evt;
  logic        lose_evt;
  logic [11:0] rgb_title;
  logic [11:0] rgb_play;
  logic [11:0] rgb_win;
  logic [11:0] rgb_lose;
  logic [3:0]  vgaRed;
  logic [3:0]  vgaGreen;
  logic [3:0]  vgaBlue;
  logic        hsync;
  logic        vsync;
  logic [1:0]  screen_id;
  logic        busy;

  modport master (
    output valid, h_cnt, v_cnt, hsync_in, vsync_in, start_btn, win_evt, lose_evt,
           rgb_title, rgb_play, rgb_win, rgb_lose,
    input  vgaRed, vgaGreen, vgaBlue, hsync, vsync, screen_id, busy
  );

  modport slave (
    input  valid, h_cnt, v_cnt, hsync_in, vsync_in, start_btn, win_evt, lose_evt,
           rgb_title, rgb_play, rgb_win, rgb_lose,
    output vgaRed, vgaGreen, vgaBlue, hsync, vsync, screen_id, busy
  );
endinterface

// File: rtl/vga_screen_sequencer.sv
// Screen selection from game events with frame-aligned fade-out/fade-in, brightness-scaled RGB.
// One pclk from inputs to vga*/hsync/vsync; screen changes happen only on the last active pixel of a frame.
module vga_screen_sequencer #(
  parameter int HD          = 640,
  parameter int VD          = 480,
  parameter int FADE_FRAMES = 2,
  parameter int HOLD_FRAMES = 300
) (
  input  logic         pclk,
  input  logic         reset,
  vga_screen_if.slave  bus
);

  localparam int SW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  // Steady states share their encoding with screen_id so FADE_IN can land on {0,target}.
  typedef enum logic [2:0] {
    S_TITLE    = 3'd0,
    S_PLAY     = 3'd1,
    S_WIN      = 3'd2,
    S_LOSE     = 3'd3,
    S_FADE_OUT = 3'd4,
    S_FADE_IN  = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    target, target_nx;
  logic [1:0]    screen_id;
  logic [4:0]    bright;
  logic [SW-1:0] step_cnt;
  logic [HW-1:0] hold_cnt;
  logic          win_pend, lose_pend;
  logic          busy;
  logic          frame_tick, step_wrap, hold_done, state_chg;
  logic [11:0]   pix;
  logic [3:0]    red_q, green_q, blue_q;
  logic          hsync_q, vsync_q;

  assign frame_tick = bus.valid && (bus.h_cnt == 10'(HD - 1)) && (bus.v_cnt == 10'(VD - 1));
  assign step_wrap  = (step_cnt == SW'(FADE_FRAMES - 1));
  assign hold_done  = (hold_cnt == HW'(HOLD_FRAMES - 1));
  assign state_chg  = (state_nx != state);

  always_ff @(posedge pclk) begin
    if (reset) begin
      state  <= S_TITLE;
      target <= 2'd0;
    end else begin
      state  <= state_nx;
      target <= target_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    target_nx = target;
    if (frame_tick) begin
      case (state)
        S_TITLE: if (bus.start_btn) begin
          state_nx  = S_FADE_OUT;
          target_nx = 2'd1;
        end
        S_PLAY: if (lose_pend || bus.lose_evt) begin
          state_nx  = S_FADE_OUT;
          target_nx = 2'd3;
        end else if (win_pend || bus.win_evt) begin
          state_nx  = S_FADE_OUT;
          target_nx = 2'd2;
        end
        S_WIN, S_LOSE: if (hold_done || bus.start_btn) begin
          state_nx  = S_FADE_OUT;
          target_nx = 2'd0;
        end
        S_FADE_OUT: if (step_wrap && bright == 5'd1) state_nx = S_FADE_IN;
        S_FADE_IN:  if (step_wrap && bright == 5'd15) state_nx = state_t'({1'b0, target});
        default:    state_nx = S_TITLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == S_FADE_OUT) || (state == S_FADE_IN);
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      bright    <= 5'd16;
      screen_id <= 2'd0;
      step_cnt  <= '0;
      hold_cnt  <= '0;
      win_pend  <= 1'b0;
      lose_pend <= 1'b0;
    end else begin
      if (state_chg)
        step_cnt <= '0;
      else if (frame_tick && busy)
        step_cnt <= step_wrap ? '0 : step_cnt + 1'b1;

      if (frame_tick && step_wrap && state == S_FADE_OUT) bright <= bright - 5'd1;
      if (frame_tick && step_wrap && state == S_FADE_IN)  bright <= bright + 5'd1;

      if (state == S_FADE_OUT && state_nx == S_FADE_IN) screen_id <= target;

      if (state_chg)
        hold_cnt <= '0;
      else if (frame_tick && (state == S_WIN || state == S_LOSE))
        hold_cnt <= hold_cnt + 1'b1;

      // Events only latch while PLAY is steady; leaving PLAY consumes them.
      if (state == S_PLAY && !state_chg) begin
        win_pend  <= win_pend  | bus.win_evt;
        lose_pend <= lose_pend | bus.lose_evt;
      end else begin
        win_pend  <= 1'b0;
        lose_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    case (screen_id)
      2'd0:    pix = bus.rgb_title;
      2'd1:    pix = bus.rgb_play;
      2'd2:    pix = bus.rgb_win;
      default: pix = bus.rgb_lose;
    endcase
  end

  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] b);
    return 4'((9'(c) * 9'(b)) >> 4);
  endfunction

  always_ff @(posedge pclk) begin
    if (reset) begin
      red_q   <= 4'd0;
      green_q <= 4'd0;
      blue_q  <= 4'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      hsync_q <= bus.hsync_in;
      vsync_q <= bus.vsync_in;
      if (bus.valid) begin
        red_q   <= scale(pix[11:8], bright);
        green_q <= scale(pix[7:4],  bright);
        blue_q  <= scale(pix[3:0],  bright);
      end else begin
        red_q   <= 4'd0;
        green_q <= 4'd0;
        blue_q  <= 4'd0;
      end
    end
  end

  assign bus.vgaRed    = red_q;
  assign bus.vgaGreen  = green_q;
  assign bus.vgaBlue   = blue_q;
  assign bus.hsync     = hsync_q;
  assign bus.vsync     = vsync_q;
  assign bus.screen_id = screen_id;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_vga_screen_sequencer.sv
// Scoreboarded bench for vga_screen_sequencer on a shrunken raster (8x4 active, 12x6 total) to keep runs short.
module tb_vga_screen_sequencer;

  localparam int HD = 8, VD = 4, HT = 12, VT = 6;
  localparam int FF = 1, HOLD = 4;

  logic pclk = 1'b0;
  logic reset = 1'b1;
  always #5 pclk = ~pclk;

  vga_screen_if bus ();

  vga_screen_sequencer #(.HD(HD), .VD(VD), .FADE_FRAMES(FF), .HOLD_FRAMES(HOLD)) dut (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic [1:0]  scr;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: a fade is one counter of ticks since it began.
  int m_scr, m_tgt, m_k, m_hold;
  bit m_fade, m_win, m_lose;

  int hc = 0, vc = 0, ticks_seen = 0;
  bit btn = 1'b0, force_white = 1'b1;

  function automatic int m_bright();
    if (!m_fade)          return 16;
    else if (m_k <= 16*FF) return 16 - m_k / FF;
    else                   return (m_k - 16*FF) / FF;
  endfunction

  function automatic logic [11:0] exp_rgb(input logic [11:0] c, input int b);
    int r, g, bl;
    r  = int'(c[11:8]) * b / 16;
    g  = int'(c[7:4])  * b / 16;
    bl = int'(c[3:0])  * b / 16;
    return {4'(r), 4'(g), 4'(bl)};
  endfunction

  task automatic model_reset();
    m_scr = 0; m_tgt = 0; m_k = 0; m_hold = 0;
    m_fade = 0; m_win = 0; m_lose = 0;
  endtask

  task automatic begin_fade(input int t);
    m_fade = 1; m_k = 0; m_tgt = t; m_win = 0; m_lose = 0;
  endtask

  task automatic model_update(input bit tick, input bit st, input bit we, input bit le);
    if (!tick) begin
      if (!m_fade && m_scr == 1) begin
        m_win  = m_win  | we;
        m_lose = m_lose | le;
      end
    end else if (m_fade) begin
      m_k++;
      if (m_k == 16*FF) m_scr = m_tgt;
      if (m_k == 32*FF) begin m_fade = 0; m_hold = 0; end
    end else begin
      case (m_scr)
        0: if (st) begin_fade(1);
        1: if (m_lose || le) begin_fade(3);
           else if (m_win || we) begin_fade(2);
        default: if (m_hold == HOLD-1 || st) begin_fade(0);
                 else m_hold++;
      endcase
    end
  endtask

  task automatic step(input bit we, input bit le, input bit rst);
    exp_t        e;
    bit          v, tick, hs, vs;
    logic [11:0] rgbs[4];
    @(negedge pclk);
    v  = (hc < HD) && (vc < VD);
    hs = !(hc >= 9 && hc < 11);
    vs = !(vc == 5);
    for (int i = 0; i < 4; i++) rgbs[i] = 12'($urandom);
    if (force_white) rgbs[0] = 12'hFFF;
    reset          = rst;
    bus.valid      = v;
    bus.h_cnt      = v ? 10'(hc) : 10'd0;
    bus.v_cnt      = v ? 10'(vc) : 10'd0;
    bus.hsync_in   = hs;
    bus.vsync_in   = vs;
    bus.start_btn  = btn;
    bus.win_evt    = we;
    bus.lose_evt   = le;
    bus.rgb_title  = rgbs[0];
    bus.rgb_play   = rgbs[1];
    bus.rgb_win    = rgbs[2];
    bus.rgb_lose   = rgbs[3];
    tick = v && hc == HD-1 && vc == VD-1;
    if (rst) begin
      e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1;
      model_reset();
    end else begin
      e.rgb = v ? exp_rgb(rgbs[m_scr], m_bright()) : 12'h000;
      e.hs  = hs;
      e.vs  = vs;
      model_update(tick, btn, we, le);
    end
    e.scr  = 2'(m_scr);
    e.busy = m_fade;
    exp_q.push_back(e);
    if (tick) ticks_seen++;
    hc++;
    if (hc == HT) begin
      hc = 0;
      vc = (vc == VT-1) ? 0 : vc + 1;
    end
  endtask

  task automatic run_ticks(input int n);
    int goal;
    goal = ticks_seen + n;
    while (ticks_seen < goal) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  // Monitor: outputs seen 1 ns after a rising edge belong to the oldest queued entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge pclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue} !== e.rgb || bus.hsync !== e.hs ||
            bus.vsync !== e.vs || bus.screen_id !== e.scr || bus.busy !== e.busy) begin
          fails++;
          $display("FAIL pixel @%0t: rgb=%h hs=%b vs=%b scr=%0d busy=%b, expected rgb=%h hs=%b vs=%b scr=%0d busy=%b",
                   $time, {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, bus.hsync, bus.vsync,
                   bus.screen_id, bus.busy, e.rgb, e.hs, e.vs, e.scr, e.busy);
        end
      end
    end
  end

  initial begin
    bus.valid = 0; bus.h_cnt = 0; bus.v_cnt = 0; bus.hsync_in = 1; bus.vsync_in = 1;
    bus.start_btn = 0; bus.win_evt = 0; bus.lose_evt = 0;
    bus.rgb_title = 0; bus.rgb_play = 0; bus.rgb_win = 0; bus.rgb_lose = 0;
    model_reset();

    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("reset_screen", bus.screen_id, 0);
    chk("reset_busy", bus.busy, 0);
    run_ticks(1);
    force_white = 1'b0;

    // TITLE -> PLAY
    btn = 1'b1; run_ticks(1); btn = 1'b0; step(1'b0, 1'b0, 1'b0);
    chk("start_busy", bus.busy, 1);
    chk("start_screen", bus.screen_id, 0);
    run_ticks(15); step(1'b0, 1'b0, 1'b0);
    chk("fadeout_no_early_switch", bus.screen_id, 0);
    run_ticks(1); step(1'b0, 1'b0, 1'b0);
    chk("play_switch", bus.screen_id, 1);
    run_ticks(16); step(1'b0, 1'b0, 1'b0);
    chk("play_steady_busy", bus.busy, 0);
    chk("play_steady_screen", bus.screen_id, 1);

    // Simultaneous win/lose mid-frame: LOSE wins, nothing moves before the tick
    repeat (30) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("evt_no_early_busy", bus.busy, 0);
    run_ticks(1); step(1'b0, 1'b0, 1'b0);
    chk("evt_fade_busy", bus.busy, 1);
    run_ticks(16); step(1'b0, 1'b0, 1'b0);
    chk("lose_switch", bus.screen_id, 3);
    run_ticks(16); step(1'b0, 1'b0, 1'b0);
    chk("lose_steady_busy", bus.busy, 0);

    // Hold timeout back to TITLE
    run_ticks(3); step(1'b0, 1'b0, 1'b0);
    chk("hold_not_expired", bus.busy, 0);
    run_ticks(1); step(1'b0, 1'b0, 1'b0);
    chk("hold_expired", bus.busy, 1);
    run_ticks(32); step(1'b0, 1'b0, 1'b0);
    chk("lose_to_title", bus.screen_id, 0);
    chk("lose_to_title_busy", bus.busy, 0);

    // win_evt during FADE_IN to PLAY is dropped
    btn = 1'b1; run_ticks(1); btn = 1'b0;
    run_ticks(20); step(1'b1, 1'b0, 1'b0);
    run_ticks(12); step(1'b0, 1'b0, 1'b0);
    chk("fadein_done", bus.busy, 0);
    run_ticks(10); step(1'b0, 1'b0, 1'b0);
    chk("play_persists_screen", bus.screen_id, 1);
    chk("play_persists_busy", bus.busy, 0);

    // WIN and its hold timeout
    step(1'b1, 1'b0, 1'b0);
    run_ticks(33); step(1'b0, 1'b0, 1'b0);
    chk("win_screen", bus.screen_id, 2);
    run_ticks(4); step(1'b0, 1'b0, 1'b0);
    chk("win_hold_expired", bus.busy, 1);
    run_ticks(32); step(1'b0, 1'b0, 1'b0);
    chk("win_to_title", bus.screen_id, 0);

    // Reset in the middle of a fade-out at brightness 5
    btn = 1'b1; run_ticks(1); btn = 1'b0;
    run_ticks(11);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("midfade_reset_busy", bus.busy, 0);
    chk("midfade_reset_screen", bus.screen_id, 0);
    run_ticks(2);

    // Random traffic
    for (int i = 0; i < 40*HT*VT; i++) begin
      if ($urandom_range(0, 149) == 0) btn = ~btn;
      step($urandom_range(0, 96) == 0, $urandom_range(0, 96) == 0, $urandom_range(0, 2999) == 0);
    end
    step(1'b0, 1'b0, 1'b0);
    @(posedge pclk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
